// File: rtl/nonce_result_arbiter.sv
// nonce_result_arbiter
// Collects golden-nonce reports from NUM_CORES hash cores, holds each in a
// per-core capture register, and serialises them through a round-robin
// arbiter into a small result FIFO that feeds the interrupt-0 data/ack path.
// Everything runs in the S_AXI_ACLK domain.
module nonce_result_arbiter #(
  parameter int NUM_CORES  = 2,
  parameter int NONCE_W    = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16,
  localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic                           i_flush,
  input  logic [NUM_CORES-1:0]           i_found,
  input  logic [NUM_CORES*NONCE_W-1:0]   i_nonce,
  output logic                           o_valid,
  output logic [NONCE_W-1:0]             o_nonce,
  output logic [CORE_W-1:0]              o_core,
  input  logic                           i_ack,
  output logic [CNT_W-1:0]               o_count,
  output logic [DROP_W-1:0]              o_drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DI_W  = $clog2(NUM_CORES + 1);
  localparam int SUM_W = DROP_W + DI_W;

  // Capture registers, one per core
  logic [NUM_CORES-1:0] cap_full;
  logic [NONCE_W-1:0]   cap_nonce [NUM_CORES];

  // Round-robin search start
  logic [CORE_W-1:0]    rr_ptr;

  // Result FIFO storage and bookkeeping
  logic [NONCE_W-1:0]   fifo_nonce [FIFO_DEPTH];
  logic [CORE_W-1:0]    fifo_core  [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [DROP_W-1:0]    drop_cnt;

  // Combinational control
  logic                 pop;
  logic                 can_accept;
  logic                 grant_vld;
  logic [CORE_W-1:0]    grant_idx;
  logic [NUM_CORES-1:0] gnt_mask;
  logic [DI_W-1:0]      drop_inc;
  logic [SUM_W-1:0]     drop_sum;
  logic [DROP_W-1:0]    drop_next;

  assign o_valid    = (count != '0);
  assign o_nonce    = fifo_nonce[rd_ptr];
  assign o_core     = fifo_core[rd_ptr];
  assign o_count    = count;
  assign o_drop_cnt = drop_cnt;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign pop        = o_valid && i_ack;
  assign can_accept = (count < CNT_W'(FIFO_DEPTH)) || pop;

  // Round-robin grant: first full capture register at or after rr_ptr, with wrap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      int c;
      c = int'(rr_ptr) + i;
      if (c >= NUM_CORES) c = c - NUM_CORES;
      if (!grant_vld && can_accept && cap_full[c]) begin
        grant_vld = 1'b1;
        grant_idx = CORE_W'(c);
      end
    end
  end

  // Per-core grant mask and number of reports lost this cycle.
  always_comb begin
    gnt_mask = '0;
    drop_inc = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      gnt_mask[k] = grant_vld && (grant_idx == CORE_W'(k));
      if (i_found[k] && cap_full[k] && !gnt_mask[k]) drop_inc = drop_inc + DI_W'(1);
    end
  end

  // Saturating add of this cycle's drops; the wide sum cannot wrap.
  always_comb begin
    drop_sum  = SUM_W'(drop_cnt) + SUM_W'(drop_inc);
    drop_next = drop_sum[DROP_W-1:0];
    if (drop_sum > SUM_W'({DROP_W{1'b1}})) drop_next = '1;
  end

  // Capture registers: load when empty or when emptied by a same-cycle grant.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values regardless of statement order.
      cap_full <= '0;
      for (int k = 0; k < NUM_CORES; k++) cap_nonce[k] <= '0;
    end else if (i_flush) begin
      cap_full <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (i_found[k] && (!cap_full[k] || gnt_mask[k])) begin
          cap_nonce[k] <= i_nonce[k*NONCE_W +: NONCE_W];
          cap_full[k]  <= 1'b1;
        end else if (gnt_mask[k]) begin
          cap_full[k]  <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer: advance past the granted core, hold otherwise.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rr_ptr <= '0;
    end else if (i_flush) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == CORE_W'(NUM_CORES - 1)) ? '0 : grant_idx + CORE_W'(1);
    end
  end

  // FIFO storage: written on every grant.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      // NOTE: the storage array is reset because o_nonce/o_core read it directly and must be zero out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_nonce[i] <= '0;
        fifo_core[i]  <= '0;
      end
    end else if (!i_flush && grant_vld) begin
      fifo_nonce[wr_ptr] <= cap_nonce[grant_idx];
      fifo_core[wr_ptr]  <= grant_idx;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant_vld) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
      case ({grant_vld, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Drop counter survives flush; only reset clears it.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      drop_cnt <= '0;
    end else if (!i_flush) begin
      drop_cnt <= drop_next;
    end
  end

endmodule

// File: tb/tb_nonce_result_arbiter.sv
// tb_nonce_result_arbiter
// Table-driven vectors, directed multi-cycle sequences and randomized traffic
// against a queue-based reference model of the result arbiter.
module tb_nonce_result_arbiter;

  localparam int NC    = 2;
  localparam int NW    = 64;
  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic            clk;
  logic            rst_n;
  logic            i_flush;
  logic [NC-1:0]   i_found;
  logic [NC*NW-1:0] i_nonce;
  logic            o_valid;
  logic [NW-1:0]   o_nonce;
  logic [0:0]      o_core;
  logic            i_ack;
  logic [2:0]      o_count;
  logic [DW-1:0]   o_drop_cnt;

  int tests = 0;
  int fails = 0;

  nonce_result_arbiter #(
    .NUM_CORES(NC), .NONCE_W(NW), .FIFO_DEPTH(DEPTH), .DROP_W(DW)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .i_flush      (i_flush),
    .i_found      (i_found),
    .i_nonce      (i_nonce),
    .o_valid      (o_valid),
    .o_nonce      (o_nonce),
    .o_core       (o_core),
    .i_ack        (i_ack),
    .o_count      (o_count),
    .o_drop_cnt   (o_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           core;
    logic [63:0]  nonce;
  } ent_t;

  ent_t        mq[$];
  bit          m_full[NC];
  logic [63:0] m_nonce[NC];
  int          m_ptr  = 0;
  int          m_drop = 0;

  task automatic model_step();
    bit pop, acc;
    int g, drops, c;
    if (i_flush) begin
      mq.delete();
      for (int k = 0; k < NC; k++) m_full[k] = 1'b0;
      m_ptr = 0;
      return;
    end
    pop = (mq.size() > 0) && i_ack;
    acc = (mq.size() < DEPTH) || pop;
    g = -1;
    if (acc) begin
      for (int i = 0; i < NC; i++) begin
        c = (m_ptr + i) % NC;
        if (g < 0 && m_full[c]) g = c;
      end
    end
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back('{g, m_nonce[g]});
      m_full[g] = 1'b0;
      m_ptr = (g + 1) % NC;
    end
    drops = 0;
    for (int k = 0; k < NC; k++) begin
      if (i_found[k]) begin
        if (!m_full[k]) begin
          m_full[k]  = 1'b1;
          m_nonce[k] = i_nonce[k*NW +: NW];
        end else begin
          drops++;
        end
      end
    end
    m_drop = (m_drop + drops > (2**DW - 1)) ? (2**DW - 1) : m_drop + drops;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        for (int k = 0; k < NC; k++) m_full[k] = 1'b0;
        m_ptr  = 0;
        m_drop = 0;
      end else begin
        model_step();
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("model_valid", 64'(o_valid), 64'(mq.size() != 0));
      check("model_count", 64'(o_count), 64'(mq.size()));
      check("model_drop", 64'(o_drop_cnt), 64'(m_drop));
      if (mq.size() != 0) begin
        check("model_nonce", o_nonce, mq[0].nonce);
        check("model_core", 64'(o_core), 64'(mq[0].core));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic idle_inputs();
    i_flush = 1'b0;
    i_found = '0;
    i_ack   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_nonces(input logic [63:0] n0, input logic [63:0] n1);
    i_nonce = {n1, n0};
  endtask

  typedef struct {
    logic        flush;
    logic [1:0]  found;
    logic [63:0] n0;
    logic [63:0] n1;
    logic        ack;
    logic        e_valid;
    logic [63:0] e_nonce;
    logic        e_core;
    logic [2:0]  e_count;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst_n   = 1'b0;
    i_flush = 1'b0;
    i_found = '0;
    i_ack   = 1'b0;
    i_nonce = '0;

    // Simultaneous finds with ack held high, then single-pulse latency and hold.
    vecs[0] = '{1'b0, 2'b11, 64'h1111, 64'h2222, 1'b1, 1'b0, 64'h0,    1'b0, 3'd0, 16'd0};
    vecs[1] = '{1'b0, 2'b00, 64'h0,    64'h0,    1'b1, 1'b1, 64'h1111, 1'b0, 3'd1, 16'd0};
    vecs[2] = '{1'b0, 2'b00, 64'h0,    64'h0,    1'b1, 1'b1, 64'h2222, 1'b1, 3'd1, 16'd0};
    vecs[3] = '{1'b0, 2'b00, 64'h0,    64'h0,    1'b1, 1'b0, 64'h0,    1'b0, 3'd0, 16'd0};
    vecs[4] = '{1'b0, 2'b10, 64'h0,    64'hABCD, 1'b0, 1'b0, 64'h0,    1'b0, 3'd0, 16'd0};
    vecs[5] = '{1'b0, 2'b00, 64'h0,    64'h0,    1'b0, 1'b1, 64'hABCD, 1'b1, 3'd1, 16'd0};
    vecs[6] = '{1'b0, 2'b00, 64'h0,    64'h0,    1'b0, 1'b1, 64'hABCD, 1'b1, 3'd1, 16'd0};
    vecs[7] = '{1'b0, 2'b00, 64'h0,    64'h0,    1'b1, 1'b0, 64'h0,    1'b0, 3'd0, 16'd0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_drop",  64'(o_drop_cnt), 64'd0);
    check("rst_nonce", o_nonce, 64'd0);
    check("rst_core",  64'(o_core), 64'd0);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      i_flush = vecs[i].flush;
      i_found = vecs[i].found;
      set_nonces(vecs[i].n0, vecs[i].n1);
      i_ack   = vecs[i].ack;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(o_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d_count", i), 64'(o_count), 64'(vecs[i].e_count));
      check($sformatf("vec%0d_drop", i),  64'(o_drop_cnt), 64'(vecs[i].e_drop));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_nonce", i), o_nonce, vecs[i].e_nonce);
        check($sformatf("vec%0d_core", i),  64'(o_core), 64'(vecs[i].e_core));
      end
    end

    // Backpressure: five pulses into a 4-deep FIFO, then an overrun drop.
    do_reset();
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      i_found = 2'b01;
      set_nonces(64'h100 + 64'(p), 64'h0);
      @(negedge clk);
      i_found = 2'b00;
    end
    @(negedge clk);
    check("bp_count", 64'(o_count), 64'd4);
    check("bp_drop",  64'(o_drop_cnt), 64'd0);
    i_found = 2'b01;
    set_nonces(64'h105, 64'h0);
    @(negedge clk);
    i_found = 2'b00;
    check("ovr_drop",  64'(o_drop_cnt), 64'd1);
    check("ovr_head",  o_nonce, 64'h100);
    i_ack = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("drain%0d_nonce", i), o_nonce, 64'h100 + 64'(i));
    end
    @(negedge clk);
    check("drain_empty", 64'(o_valid), 64'd0);
    check("drain_drop",  64'(o_drop_cnt), 64'd1);
    i_ack = 1'b0;

    // Both cores pulse for 8 cycles with ack high: grants alternate.
    // The first pulse fills both empty capture regs; each later pulse loses
    // the non-granted core's report, giving 7 drops.
    do_reset();
    i_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) check($sformatf("rr%0d_core", i), 64'(o_core), 64'((i - 2) & 1));
      i_found = 2'b11;
      set_nonces({32'h0, $urandom}, {32'h0, $urandom});
    end
    @(negedge clk);
    i_found = 2'b00;
    repeat (3) @(negedge clk);
    check("rr_drop", 64'(o_drop_cnt), 64'd7);
    i_ack = 1'b0;

    // Flush with 3 entries queued and both captures full.
    do_reset();
    @(negedge clk);
    i_found = 2'b11; set_nonces(64'hA0, 64'hA1);
    @(negedge clk);
    i_found = 2'b00;
    @(negedge clk);
    @(negedge clk);
    i_found = 2'b11; set_nonces(64'hB0, 64'hB1);
    @(negedge clk);
    i_found = 2'b01; set_nonces(64'hC0, 64'h0);
    @(negedge clk);
    i_found = 2'b00;
    check("fl_pre_count", 64'(o_count), 64'd3);
    i_flush = 1'b1; i_ack = 1'b1; i_found = 2'b11;
    @(negedge clk);
    check("fl_valid", 64'(o_valid), 64'd0);
    check("fl_count", 64'(o_count), 64'd0);
    check("fl_drop",  64'(o_drop_cnt), 64'd0);
    i_flush = 1'b0; i_ack = 1'b0; i_found = 2'b11; set_nonces(64'hD0, 64'hD1);
    @(negedge clk);
    i_found = 2'b00;
    @(negedge clk);
    check("fl_post_valid", 64'(o_valid), 64'd1);
    check("fl_post_core",  64'(o_core), 64'd0);
    check("fl_post_nonce", o_nonce, 64'hD0);

    // Asynchronous reset mid-burst, then single-pulse latency.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_found = 2'b11;
      set_nonces(64'h300 + 64'(i), 64'h400 + 64'(i));
    end
    @(negedge clk);
    i_found = 2'b00;
    check("ar_pre_count", 64'(o_count), 64'd3);
    check("ar_pre_drop",  64'(o_drop_cnt), 64'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(o_valid), 64'd0);
    check("ar_count", 64'(o_count), 64'd0);
    check("ar_drop",  64'(o_drop_cnt), 64'd0);
    check("ar_nonce", o_nonce, 64'd0);
    check("ar_core",  64'(o_core), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    i_found = 2'b10; set_nonces(64'h0, 64'hBEEF);
    @(negedge clk);
    i_found = 2'b00;
    check("ar_lat1_valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    check("ar_lat2_valid", 64'(o_valid), 64'd1);
    check("ar_lat2_nonce", o_nonce, 64'hBEEF);
    check("ar_lat2_core",  64'(o_core), 64'd1);

    // Randomized traffic against the model, with varying ack pressure.
    do_reset();
    for (int phase = 0; phase < 3; phase++) begin
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        i_flush = ($urandom_range(0, 40) == 0);
        i_found = NC'($urandom);
        set_nonces({$urandom, $urandom}, {$urandom, $urandom});
        case (phase)
          0:       i_ack = ($urandom_range(0, 3) != 0);
          1:       i_ack = ($urandom_range(0, 3) == 0);
          default: i_ack = $urandom_range(0, 1) == 1;
        endcase
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
